min_frame_tracker: RTL and testbench
====================================

Name: min_frame_tracker

Overview:
- Streaming reduction stage that consumes the 8-bit minimum values produced by the two-input minimum comparator.
- Reduces each frame of samples to one result: the frame minimum, the index of its first occurrence, and the frame sample count.
- Uses valid/ready handshakes on both sides. Feeds the downstream result consumer.

Parameters:
DATA_W, 8, sample width in bits
FRAME_LEN, 16, maximum samples per frame (>=1)
IDX_W, $clog2(FRAME_LEN) (min 1), width of the index field

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream sample valid
in_ready  output  1  block can accept a sample
in_data  input  DATA_W  sample value (unsigned)
in_last  input  1  marks the final sample of a short frame; qualified by in_valid
out_valid  output  1  frame result valid
out_ready  input  1  downstream accepts result
out_min  output  DATA_W  frame minimum
out_idx  output  IDX_W  index of first occurrence of the minimum within the frame
out_count  output  IDX_W+1  number of samples in the frame

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. Reset and clock are fixed as stated.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_min=0, out_idx=0, out_count=0. Internal cur_min, cur_idx and count are cleared.
- Transfer rule: a transfer occurs when valid && ready on the same rising edge. Once valid is asserted, it may not drop until the transfer. This block holds out_* stable while out_valid=1 and out_ready=0.
- State IDLE:
  - in_ready=1.
  - On an accepted sample: cur_min=in_data, cur_idx=0, count=1.
  - Next state is HOLD if in_last=1 or FRAME_LEN==1; otherwise ACCUM.
- State ACCUM:
  - in_ready=1.
  - On an accepted sample: if in_data < cur_min (strictly unsigned), then cur_min=in_data and cur_idx=count. Otherwise cur_min and cur_idx are unchanged; on ties the earliest index is kept. In all cases count=count+1.
  - Next state is HOLD when in_last=1 or the new count==FRAME_LEN.
  - With no transfer, state and registers are held.
- State HOLD:
  - in_ready=0, out_valid=1.
  - out_min, out_idx and out_count are driven from the registered values.
  - On out_ready=1: next state IDLE, count cleared.
- Latency: out_valid rises on the cycle after the edge that accepts the frame's final sample.
- Throughput: one bubble cycle per frame minimum (HOLD → IDLE). Each additional cycle of out_ready=0 adds one more stall cycle.
- in_last while in IDLE produces a 1-sample frame.
- in_last on the FRAME_LEN-th sample is the same as a normal frame end; there is no double result.
- count never exceeds FRAME_LEN and never wraps.
- in_data changes while in_valid=0 are ignored.
- Comparison is done by the min2_idx sub-module. Its outputs are combinational and feed the register inputs only.
- Reset asserted mid-frame or in HOLD: all state clears immediately. No result is emitted and the partial frame is discarded.
- No X propagation: outputs are always driven from registers.

Decomposition:
- Package min_pkg holds:
  - constants DATA_W_DEF=8 and FRAME_LEN_DEF=16;
  - the enumerated state type {IDLE, ACCUM, HOLD}, 2-bit encoding;
  - a function returning the index width.
- Sub-module min2_idx (combinational), ports:
  - inputs: a, b, a_idx, b_idx;
  - outputs: min_val, min_idx.
  - Returns b and b_idx only when b < a, so ties favour a.
- Top level contains the FSM, counter, registers and handshake logic.

Test Plan:
- Full frame, FRAME_LEN=16:
  - Stimulus: samples 50,40,...,then 7 at index 9, remainder 20, out_ready=1.
  - Response: out_valid one cycle after the 16th accept; out_min=7, out_idx=9, out_count=16.
- Ties:
  - Stimulus: frame 9,3,5,3,3..., with the minimum 3 first seen at index 1.
  - Response: out_min=3, out_idx=1 (earliest kept).
- Early termination:
  - Stimulus: 4 samples 200,100,255,150 with in_last on the 4th.
  - Response: out_min=100, out_idx=1, out_count=4.
  - Stimulus: 1-sample frame of 0x80 with in_last.
  - Response: out_min=0x80, out_idx=0, out_count=1.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles after out_valid rises, while upstream holds in_valid=1.
  - Response: in_ready=0 and outputs stable for all 5 cycles. The result transfers on the first cycle with out_ready=1. The next frame's first sample is accepted the following cycle.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 asynchronously (between clock edges) after 7 samples, release, then send a fresh 16-sample frame with minimum 12 at index 0.
  - Response: all outputs are 0 immediately on assertion, no stale result appears, and the next result is out_min=12, out_idx=0, out_count=16.
- Extremes and throughput:
  - Stimulus: a frame of all 0xFF with continuous in_valid and out_ready=1.
  - Response: out_min=0xFF, out_idx=0.
  - Stimulus: back-to-back frames.
  - Response: exactly one bubble per frame; 16 frames complete in 16×17 cycles.

Source files
------------

// File: rtl/min_pkg.sv
// Shared types and sizing helpers for the frame-minimum tracker.
package min_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int FRAME_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Index field is at least one bit wide, even for single-sample frames.
  function automatic int idx_width(input int frame_len);
    return (frame_len > 1) ? $clog2(frame_len) : 1;
  endfunction

endpackage

// File: rtl/min2_idx.sv
// Two-input unsigned minimum carrying an index; ties resolve to input a.
// Purely combinational, no handshake.
module min2_idx #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [IDX_W-1:0]  b_idx,
  output logic [DATA_W-1:0] min_val,
  output logic [IDX_W-1:0]  min_idx
);

  logic take_b;

  assign take_b  = (b < a);
  assign min_val = take_b ? b : a;
  assign min_idx = take_b ? b_idx : a_idx;

endmodule

// File: rtl/min_frame_tracker.sv
// Reduces each sample frame to {minimum, first index of minimum, sample count}.
// Latency: result valid the cycle after the frame's last sample is accepted.
// Backpressure: in_ready drops while a result waits; result held until out_ready.
module min_frame_tracker
  import min_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int IDX_W     = idx_width(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_idx,
  output logic [IDX_W:0]    out_count
);

  localparam logic [IDX_W:0] LEN_C = (IDX_W+1)'(FRAME_LEN);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] cur_min, cur_min_nxt;
  logic [IDX_W-1:0]  cur_idx, cur_idx_nxt;
  logic [IDX_W:0]    count, count_nxt, count_inc;
  logic [DATA_W-1:0] cmp_min;
  logic [IDX_W-1:0]  cmp_idx;
  logic              in_fire;

  assign in_ready  = (state != HOLD);
  assign out_valid = (state == HOLD);
  assign in_fire   = in_valid && in_ready;
  assign count_inc = count + (IDX_W+1)'(1);

  // While accumulating, count is always below FRAME_LEN, so its low bits are the new sample's index.
  min2_idx #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cmp (
    .a       (cur_min),
    .b       (in_data),
    .a_idx   (cur_idx),
    .b_idx   (count[IDX_W-1:0]),
    .min_val (cmp_min),
    .min_idx (cmp_idx)
  );

  always_comb begin
    state_nxt   = state;
    cur_min_nxt = cur_min;
    cur_idx_nxt = cur_idx;
    count_nxt   = count;
    case (state)
      IDLE: begin
        if (in_fire) begin
          cur_min_nxt = in_data;
          cur_idx_nxt = '0;
          count_nxt   = (IDX_W+1)'(1);
          state_nxt   = (in_last || FRAME_LEN == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (in_fire) begin
          cur_min_nxt = cmp_min;
          cur_idx_nxt = cmp_idx;
          count_nxt   = count_inc;
          if (in_last || count_inc == LEN_C) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_min <= '0;
      cur_idx <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      cur_min <= cur_min_nxt;
      cur_idx <= cur_idx_nxt;
      count   <= count_nxt;
    end
  end

  assign out_min   = cur_min;
  assign out_idx   = cur_idx;
  assign out_count = count;

endmodule

// File: tb/tb_min_frame_tracker.sv
// Directed bench for min_frame_tracker: frame vector table plus backpressure, reset and throughput sequences.
module tb_min_frame_tracker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_min;
  logic [3:0] out_idx;
  logic [4:0] out_count;

  int checks;
  int failures;
  int cyc;

  min_frame_tracker #(
    .DATA_W    (8),
    .FRAME_LEN (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_count (out_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Entered at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send(input logic [7:0] d, input logic last);
    int budget;
    budget = 50;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("send_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  typedef struct {
    logic [0:15][7:0] d;
    int               len;
    bit               last;
    int               emin;
    int               eidx;
    int               ecnt;
  } vec_t;

  vec_t vecs [6];
  int   c0;
  int   c1;

  initial begin
    vecs[0].d = {8'd50, 8'd40, 8'd35, 8'd30, 8'd28, 8'd26, 8'd24, 8'd22,
                 8'd21, 8'd7,  8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 8'd20};
    vecs[0].len = 16; vecs[0].last = 0; vecs[0].emin = 7;   vecs[0].eidx = 9;  vecs[0].ecnt = 16;
    vecs[1].d = {8'd9, 8'd3, 8'd5, 8'd3, 8'd3, 8'd4, 8'd8, 8'd3,
                 8'd10, 8'd3, 8'd6, 8'd3, 8'd3, 8'd7, 8'd3, 8'd9};
    vecs[1].len = 16; vecs[1].last = 0; vecs[1].emin = 3;   vecs[1].eidx = 1;  vecs[1].ecnt = 16;
    vecs[2].d = {8'd200, 8'd100, 8'd255, 8'd150, 96'd0};
    vecs[2].len = 4;  vecs[2].last = 1; vecs[2].emin = 100; vecs[2].eidx = 1;  vecs[2].ecnt = 4;
    vecs[3].d = {8'h80, 120'd0};
    vecs[3].len = 1;  vecs[3].last = 1; vecs[3].emin = 128; vecs[3].eidx = 0;  vecs[3].ecnt = 1;
    vecs[4].d = {16{8'hFF}};
    vecs[4].len = 16; vecs[4].last = 0; vecs[4].emin = 255; vecs[4].eidx = 0;  vecs[4].ecnt = 16;
    vecs[5].d = {8'd30, 8'd29, 8'd28, 8'd27, 8'd26, 8'd25, 8'd24, 8'd23,
                 8'd22, 8'd21, 8'd20, 8'd19, 8'd18, 8'd17, 8'd16, 8'd15};
    vecs[5].len = 16; vecs[5].last = 1; vecs[5].emin = 15;  vecs[5].eidx = 15; vecs[5].ecnt = 16;

    checks = 0; failures = 0; cyc = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_in_ready",  int'(in_ready),  1);
    chk("reset_out_min",   int'(out_min),   0);
    chk("reset_out_idx",   int'(out_idx),   0);
    chk("reset_out_count", int'(out_count), 0);

    // in_data wiggling without in_valid must not start a frame.
    in_data = 8'h01;
    @(negedge clk);
    in_data = 8'h02;
    @(negedge clk);
    chk("idle_ignore_count", int'(out_count), 0);

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < vecs[v].len; i++)
        send(vecs[v].d[i], vecs[v].last && (i == vecs[v].len - 1));
      chk($sformatf("v%0d_latency", v), int'(out_valid), 1);
      chk($sformatf("v%0d_min", v),     int'(out_min),   vecs[v].emin);
      chk($sformatf("v%0d_idx", v),     int'(out_idx),   vecs[v].eidx);
      chk($sformatf("v%0d_count", v),   int'(out_count), vecs[v].ecnt);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_single_result", v), int'(out_valid), 0);
    end

    // Backpressure: result held 5 cycles while upstream keeps offering a 1-sample frame.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(vecs[2].d[i], i == 3);
    in_valid = 1'b1; in_data = 8'h33; in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_in_ready", k),  int'(in_ready),  0);
      chk($sformatf("bp%0d_out_valid", k), int'(out_valid), 1);
      chk($sformatf("bp%0d_min", k),       int'(out_min),   100);
      chk($sformatf("bp%0d_idx", k),       int'(out_idx),   1);
      chk($sformatf("bp%0d_count", k),     int'(out_count), 4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_out_valid", int'(out_valid), 0);
    chk("bp_released_in_ready",  int'(in_ready),  1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_next_out_valid", int'(out_valid), 1);
    chk("bp_next_min",       int'(out_min),   8'h33);
    chk("bp_next_count",     int'(out_count), 1);
    @(negedge clk);

    // Reset mid-frame: 7 samples in, reset asserted between edges.
    for (int i = 0; i < 7; i++) send(8'(40 - i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_out_valid", int'(out_valid), 0);
    chk("rst_async_in_ready",  int'(in_ready),  1);
    chk("rst_async_out_min",   int'(out_min),   0);
    chk("rst_async_out_idx",   int'(out_idx),   0);
    chk("rst_async_out_count", int'(out_count), 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_out_valid", int'(out_valid), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_stale_result", int'(out_valid), 0);
    for (int i = 0; i < 16; i++) send((i % 4 == 0) ? 8'd12 : 8'(20 + i), 1'b0);
    chk("rst_frame_valid", int'(out_valid), 1);
    chk("rst_frame_min",   int'(out_min),   12);
    chk("rst_frame_idx",   int'(out_idx),   0);
    chk("rst_frame_count", int'(out_count), 16);
    @(posedge clk);
    @(negedge clk);

    // Back-to-back full frames: frame f has its minimum value f at index f.
    c0 = cyc;
    for (int f = 0; f < 16; f++) begin
      for (int i = 0; i < 16; i++) send((i == f) ? 8'(f) : 8'(100 + i), 1'b0);
      chk($sformatf("tp%0d_valid", f), int'(out_valid), 1);
      chk($sformatf("tp%0d_min", f),   int'(out_min),   f);
      chk($sformatf("tp%0d_idx", f),   int'(out_idx),   f);
    end
    @(posedge clk);
    @(negedge clk);
    c1 = cyc;
    chk("throughput_cycles", c1 - c0, 16 * 17);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
